// File: rtl/coh_noc_pkg.sv
// Shared definitions for the coherent NoC: flit format, virtual channels,
// buffer sizing and the credit-return record used by both link ends.
package coh_noc_pkg;

  localparam int VC_BUFFER_DEPTH = 16;
  localparam int NUM_VCS         = 4;
  localparam int VC_W            = 2;

  typedef enum logic [1:0] {
    VC_REQ = 2'd0,
    VC_RSP = 2'd1,
    VC_DAT = 2'd2,
    VC_SNP = 2'd3
  } virtual_channel_e;

  localparam logic [7:0] REQ_READ_SHARED = 8'h01;
  localparam logic [7:0] REQ_WRITE_BACK  = 8'h08;
  localparam logic [7:0] SNP_INVALIDATE  = 8'h30;
  localparam logic [7:0] RSP_COMP_DATA   = 8'h52;

  typedef struct packed {
    logic [7:0]   opcode;
    logic [11:0]  txn_id;
    logic [7:0]   src_id;
    logic [7:0]   dst_id;
    logic [47:0]  addr;
    logic [3:0]   qos;
    logic         last;
    logic         poison;
    logic [8:0]   rsvd;
    logic [511:0] data;
  } flit_t;

  localparam int FLIT_W = $bits(flit_t);

  typedef struct packed {
    logic            valid;
    logic [VC_W-1:0] vc;
  } credit_rtn_t;

  // Round-robin successor; the 2-bit VC wraps 3 -> 0 on its own.
  function automatic logic [VC_W-1:0] vc_inc(input logic [VC_W-1:0] vc);
    return vc + VC_W'(1);
  endfunction

endpackage

// File: rtl/coh_noc_fifo.sv
// First-word-fall-through FIFO: the head entry is always visible on pop_data.
// Full/empty come from the occupancy counter so the pointers can wrap freely.
module coh_noc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [OCC_W-1:0] occ,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (occ_reg == OCC_W'(DEPTH));
  assign empty = (occ_reg == '0);
  assign occ   = occ_reg;

  // Fullness is judged on pre-edge occupancy, so a same-cycle pop never
  // frees a slot for a push into a full FIFO.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Storage carries no reset; only entries below occ are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_reg];

endmodule

// File: rtl/coh_noc_vc_rx.sv
// Receive end of the credit-based VC link: four per-VC FIFOs, a locking
// round-robin output arbiter and a registered one-per-cycle credit return.
module coh_noc_vc_rx
  import coh_noc_pkg::*;
#(
  parameter int DEPTH = VC_BUFFER_DEPTH,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [VC_W-1:0]                 in_vc,
  input  flit_t                           in_flit,
  output logic                            crd_rtn_valid,
  output logic [VC_W-1:0]                 crd_rtn_vc,
  output logic                            out_valid,
  output logic [VC_W-1:0]                 out_vc,
  output flit_t                           out_flit,
  input  logic                            out_ready,
  output logic [NUM_VCS-1:0][OCC_W-1:0]   occ,
  output logic                            err_overflow
);

  logic [NUM_VCS-1:0] push_vec;
  logic [NUM_VCS-1:0] pop_vec;
  logic [NUM_VCS-1:0] full_vec;
  logic [NUM_VCS-1:0] empty_vec;
  flit_t              head_flit [NUM_VCS];

  logic [VC_W-1:0] rr_reg, rr_next;
  logic            lock_reg, lock_next;
  logic [VC_W-1:0] lock_vc_reg, lock_vc_next;
  credit_rtn_t     crd_reg, crd_next;
  logic            err_overflow_reg, err_overflow_next;

  logic [VC_W-1:0] rr_pick;
  logic [VC_W-1:0] cand;
  logic            found;
  logic [VC_W-1:0] grant_vc;
  logic            dequeue;
  logic            overflow_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VCS; gi++) begin : g_vc
      assign push_vec[gi] = in_valid && (in_vc == VC_W'(gi));
      assign pop_vec[gi]  = dequeue && (grant_vc == VC_W'(gi));

      coh_noc_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_vec[gi]),
        .push_data (in_flit),
        .pop       (pop_vec[gi]),
        .pop_data  (head_flit[gi]),
        .occ       (occ[gi]),
        .full      (full_vec[gi]),
        .empty     (empty_vec[gi])
      );
    end
  endgenerate

  // First non-empty VC at or after the round-robin pointer.
  always_comb begin
    rr_pick = rr_reg;
    cand    = rr_reg;
    found   = 1'b0;
    for (int i = 0; i < NUM_VCS; i++) begin
      cand = rr_reg + VC_W'(i);
      if (!found && !empty_vec[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  // A locked VC cannot drain behind our back (only this port pops it), so
  // the held grant always points at a non-empty FIFO.
  assign grant_vc     = lock_reg ? lock_vc_reg : rr_pick;
  assign out_valid    = ~&empty_vec;
  assign dequeue      = out_valid && out_ready;
  assign out_vc       = out_valid ? grant_vc : '0;
  assign out_flit     = out_valid ? head_flit[grant_vc] : '0;
  assign overflow_hit = in_valid && full_vec[in_vc];

  always_comb begin
    rr_next           = rr_reg;
    lock_next         = lock_reg;
    lock_vc_next      = lock_vc_reg;
    crd_next          = '0;
    err_overflow_next = err_overflow_reg | overflow_hit;
    if (dequeue) begin
      lock_next      = 1'b0;
      rr_next        = vc_inc(grant_vc);
      crd_next.valid = 1'b1;
      crd_next.vc    = grant_vc;
    end else if (out_valid) begin
      lock_next    = 1'b1;
      lock_vc_next = grant_vc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg           <= '0;
      lock_reg         <= 1'b0;
      lock_vc_reg      <= '0;
      crd_reg          <= '0;
      err_overflow_reg <= 1'b0;
    end else begin
      rr_reg           <= rr_next;
      lock_reg         <= lock_next;
      lock_vc_reg      <= lock_vc_next;
      crd_reg          <= crd_next;
      err_overflow_reg <= err_overflow_next;
    end
  end

  assign crd_rtn_valid = crd_reg.valid;
  assign crd_rtn_vc    = crd_reg.vc;
  assign err_overflow  = err_overflow_reg;

endmodule

// File: doc/coh_noc_vc_rx.md
# coh_noc_vc_rx

Receive end of the credit-based virtual-channel flit link. The block accepts `flit_t` flits tagged with a `virtual_channel_e` VC from an upstream transmitter and buffers them in four per-VC FIFOs (REQ/RSP/DAT/SNP). It returns one credit upstream per dequeued flit and presents the buffered flits to the local consumer through a round-robin valid/ready port. It sits at every router input and at every endpoint ingress of the coherent NoC.

## Interface
- `DEPTH`, default `VC_BUFFER_DEPTH` (16): flits per VC FIFO; power of two, ≥2.
- `OCC_W`, default `$clog2(DEPTH+1)` (5): occupancy counter width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: a flit is present on the link this cycle.
- `in_vc` in 2: VC of the incoming flit (`virtual_channel_e`).
- `in_flit` in `$bits(flit_t)` (611): incoming flit.
- `crd_rtn_valid` out 1: one credit returned this cycle.
- `crd_rtn_vc` out 2: VC of the returned credit.
- `out_valid` out 1: the head flit of the granted VC is available.
- `out_vc` out 2: VC of the presented flit.
- `out_flit` out 611: presented flit.
- `out_ready` in 1: the consumer accepts the flit.
- `occ` out 4×`OCC_W`: per-VC occupancy, indexed by VC encoding.
- `err_overflow` out 1: sticky flag, set on a write to a full VC.

## Operation
- **Enqueue.** When `in_valid`=1, `in_flit` is written to FIFO[`in_vc`] if that FIFO is not full, and `occ[in_vc]` increments.
- **Overflow.** A write to a VC whose pre-edge occupancy equals `DEPTH` is an overflow:
  - the flit is dropped and `occ` is unchanged by the write;
  - `err_overflow` is set to 1 and held until `rst`;
  - a dequeue from the same VC in the same cycle does not make room for the write.
- **Credit contract.** The upstream transmitter initializes each VC credit counter to `DEPTH` at its own reset. This block never emits initial credits.
- **Arbitration.**
  - A round-robin pointer `rr` (2 bits) selects the first non-empty VC at or after `rr`, wrapping 3→0.
  - `out_valid` = any VC non-empty.
  - `out_vc` and `out_flit` come from the head of the granted FIFO (first-word fall-through).
- **Grant lock.** While `out_valid`=1 and `out_ready`=0, the grant is held. `out_vc` and `out_flit` must not change, even if a higher-priority VC becomes non-empty.
- **Dequeue.**
  - A dequeue happens on `out_valid && out_ready`.
  - The granted FIFO's read pointer advances and `occ` decrements.
  - `rr` is set to granted VC + 1 (mod 4) and the lock is released.
- **Credit return.**
  - Each dequeue produces `crd_rtn_valid`=1 with `crd_rtn_vc`=granted VC on the following cycle (registered).
  - At most one credit is returned per cycle.
- **Simultaneous enqueue and dequeue on the same non-full VC.** Both take effect and `occ` is unchanged.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally. Full and empty are derived from `occ`, not from the pointers.

## Timing
- Enqueue-to-output latency is 1 cycle: a flit written at edge N is visible on `out_*` after edge N, provided it wins arbitration.
- Dequeue-to-credit latency is 1 cycle.
- There is no combinational path from `in_*` to `out_*`, and none from `out_ready` to `crd_rtn_*`.
- `out_valid` depends only on registered occupancy. `out_ready` may be driven combinationally from `out_valid`.
- Reset values:
  - `occ`=0 and all FIFO pointers=0;
  - `rr`=0 (VC_REQ first) and the grant lock is cleared;
  - `out_valid`=0, `out_vc`=0, `out_flit`=0 (no flit is presented);
  - `crd_rtn_valid`=0, `crd_rtn_vc`=0, `err_overflow`=0.
- **Reset mid-operation.** Buffered flits are discarded and no credits are returned for them. The upstream transmitter is reset in the same reset domain.
- FIFO storage may be left unreset. Only pointers, counters and flags reset.

## Structure
- **Shared package (`coh_noc_pkg`).**
  - Uses the existing `flit_t`, `virtual_channel_e` and `VC_BUFFER_DEPTH`.
  - Adds `NUM_VCS = 4` to the package.
  - Adds a `credit_rtn_t` struct {valid, vc} to the package, for reuse by the transmit side.
- **Sub-module.** One sub-module, `coh_noc_fifo`: a parameterized FWFT FIFO (width, depth) with push, pop, occupancy, full and empty. It is instantiated four times.
- **Top level.** The arbiter, grant lock, credit register and overflow flag live in `coh_noc_vc_rx` itself.

## Test plan
- **Reset check.** Hold `rst` for 3 cycles, then release. Required: all outputs are 0 and `occ`={0,0,0,0}.
- **Single flit.** Write one flit on VC_DAT with opcode `RSP_COMP_DATA` (0x52) and txn_id 0x123, with `out_ready`=1. Required:
  - on the next cycle, `out_valid`=1, `out_vc`=2 and the flit fields match;
  - on the cycle after that, `crd_rtn_valid`=1 and `crd_rtn_vc`=2.
- **Round-robin.** Preload 2 flits on each of the 4 VCs with `out_ready`=0, then raise `out_ready`. Required:
  - dequeue order is VC 0,1,2,3,0,1,2,3;
  - 8 credits are returned, one per cycle, in the same order.
- **Grant lock.** Make VC_SNP non-empty and let it be granted (`rr`=3) with `out_ready`=0, then write VC_REQ. Required: `out_vc` stays 3 and `out_flit` is stable until `out_ready`=1; VC_REQ is granted next.
- **Full plus concurrent dequeue.** Fill VC_REQ to 16. Write a 17th flit in the same cycle as a dequeue of VC_REQ. Required: `err_overflow`=1, `occ[0]`=15, and the 17th flit is never output.
- **Reset mid-operation.** With 5 flits buffered on VC_RSP, assert `rst` asynchronously mid-cycle. Required: `occ` and `out_valid` drop to 0 immediately, and no credits are returned after release.
